scanline_plane_merger: RTL and testbench

Downstream consumer of the BMP pixel provider. Per scanline, top row first, the provider emits one plane of W green bytes followed by one plane of W red bytes. This block pulls those bytes with a request strobe and buffers the green plane in a line RAM. It then merges each arriving red byte with its stored green byte into one pixel on a valid/ready stream, tagged with x/y, start-of-frame and end-of-line, for the display driver.

---
 rtl/pixel_pkg.sv | 19 +
 rtl/plane_line_ram.sv | 36 +++
 rtl/scanline_plane_merger.sv | 222 ++++++++++++++++++++++
 tb/tb_scanline_plane_merger.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the scanline plane merger slice.
//   DEF_W / DEF_H : default scanline width and frame height
//   state_e       : merger FSM states
//   pixel_t       : 16-bit output pixel word
package pixel_pkg;

  localparam int unsigned DEF_W = 320;
  localparam int unsigned DEF_H = 256;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_G,
    FETCH_R,
    DONE
  } state_e;

  typedef logic [15:0] pixel_t;

endpackage

// File: rtl/plane_line_ram.sv
// One-line buffer holding the green plane of the current scanline.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write column
//   wr_data : green byte (or 1-bit green flag in threshold builds)
//   rd_addr : read column, data appears on rd_data one cycle later
//   rd_data : registered read data
// No reset: contents are rewritten every line before being read.
module plane_line_ram
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_W,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/scanline_plane_merger.sv
// Pulls one green plane and one red plane per scanline from the pixel
// provider, buffers green in a line RAM and emits merged pixels on a
// valid/ready stream tagged with x/y, start-of-frame and end-of-line.
//   clk, rst    : clock, synchronous active-low reset
//   src_ok      : provider loaded, bytes may be requested
//   src_req     : byte request strobe (data returns next cycle on src_data)
//   src_data    : provider byte
//   pix_valid / pix_ready / pix_data : output pixel stream ({R,G})
//   pix_x, pix_y, pix_sof, pix_eol   : pixel tags
//   frame_done  : all W*H pixels transferred, sticky until reset
// Build option: PLANE_THRESHOLD_EN reduces each plane to a 1-bit
// (value >= THRESH) flag; pix_data becomes {14'b0, r, g}.
module scanline_plane_merger
  import pixel_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned H      = DEF_H,
  parameter logic [7:0]  THRESH = 8'd128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_ok,
  output logic                 src_req,
  input  logic [7:0]           src_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [15:0]          pix_data,
  output logic [$clog2(W)-1:0] pix_x,
  output logic [$clog2(H)-1:0] pix_y,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 frame_done
);

  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

`ifdef PLANE_THRESHOLD_EN
  localparam int unsigned GW = 1;
`else
  localparam int unsigned GW = 8;
`endif

  state_e          state_q, state_d;
  logic [XW-1:0]   req_x_q, req_x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            inflight_q, inflight_d;
  logic [XW-1:0]   inflight_x_q, inflight_x_d;
  logic            g_wr_pend_q, g_wr_pend_d;
  logic [XW-1:0]   g_wr_addr_q, g_wr_addr_d;
  logic            r_last_q, r_last_d;
  logic            pix_valid_q, pix_valid_d;
  pixel_t          pix_data_q, pix_data_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic            pix_sof_q, pix_sof_d;
  logic            pix_eol_q, pix_eol_d;
  logic            frame_done_q, frame_done_d;

  logic            req;
  logic [GW-1:0]   ram_wr_data;
  logic [GW-1:0]   ram_rd_data;
  pixel_t          pix_word;
  logic            xfer;

`ifdef PLANE_THRESHOLD_EN
  assign ram_wr_data = src_data >= THRESH;
  assign pix_word    = {14'b0, src_data >= THRESH, ram_rd_data};
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign ram_wr_data   = src_data;
  assign pix_word      = {src_data, ram_rd_data};
`endif

  // Read address rides with the R request so the stored green value
  // lines up with src_data on the following cycle.
  plane_line_ram #(
    .DEPTH (W),
    .DW    (GW),
    .AW    (XW)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (g_wr_pend_q),
    .wr_addr (g_wr_addr_q),
    .wr_data (ram_wr_data),
    .rd_addr (req_x_q),
    .rd_data (ram_rd_data)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (src_ok) state_d = FETCH_G;
      FETCH_G: if (req_x_q == X_LAST) state_d = FETCH_R;
      // Leaves one cycle after the last R request; that cycle is the
      // line transition and the final R byte lands during it.
      FETCH_R: if (r_last_q) state_d = (y_q == Y_LAST) ? DONE : FETCH_G;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The first FETCH_R cycle is held off while the last
  // green byte is still being written.
  always_comb begin
    req = 1'b0;
    unique case (state_q)
      FETCH_G: req = 1'b1;
      FETCH_R: req = !r_last_q && !inflight_q && !g_wr_pend_q &&
                     (!pix_valid_q || pix_ready);
      default: req = 1'b0;
    endcase
  end

  assign xfer = pix_valid_q && pix_ready;

  // Counters, in-flight tracking and output register
  always_comb begin
    req_x_d      = req_x_q;
    y_d          = y_q;
    inflight_d   = 1'b0;
    inflight_x_d = inflight_x_q;
    g_wr_pend_d  = 1'b0;
    g_wr_addr_d  = g_wr_addr_q;
    r_last_d     = r_last_q;
    pix_valid_d  = pix_valid_q;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_sof_d    = pix_sof_q;
    pix_eol_d    = pix_eol_q;
    frame_done_d = frame_done_q;

    if (req) begin
      req_x_d = (req_x_q == X_LAST) ? '0 : req_x_q + 1'b1;
      if (state_q == FETCH_G) begin
        g_wr_pend_d = 1'b1;
        g_wr_addr_d = req_x_q;
      end else begin
        inflight_d   = 1'b1;
        inflight_x_d = req_x_q;
        if (req_x_q == X_LAST) r_last_d = 1'b1;
      end
    end

    if (state_q == FETCH_R && state_d != FETCH_R) begin
      r_last_d = 1'b0;
      if (state_d == FETCH_G && y_q != Y_LAST) y_d = y_q + 1'b1;
    end

    if (xfer) begin
      pix_valid_d = 1'b0;
      if (pix_x_q == X_LAST && pix_y_q == Y_LAST) frame_done_d = 1'b1;
    end

    if (inflight_q) begin
      pix_valid_d = 1'b1;
      pix_data_d  = pix_word;
      pix_x_d     = inflight_x_q;
      pix_y_d     = y_q;
      pix_sof_d   = (inflight_x_q == '0) && (y_q == '0);
      pix_eol_d   = inflight_x_q == X_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_x_q      <= '0;
      y_q          <= '0;
      inflight_q   <= 1'b0;
      inflight_x_q <= '0;
      g_wr_pend_q  <= 1'b0;
      g_wr_addr_q  <= '0;
      r_last_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      req_x_q      <= req_x_d;
      y_q          <= y_d;
      inflight_q   <= inflight_d;
      inflight_x_q <= inflight_x_d;
      g_wr_pend_q  <= g_wr_pend_d;
      g_wr_addr_q  <= g_wr_addr_d;
      r_last_q     <= r_last_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign src_req    = req;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eol    = pix_eol_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scanline_plane_merger.sv
// Scoreboard bench for scanline_plane_merger with W=4, H=2.
module tb_scanline_plane_merger;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_ok;
  logic          src_req;
  logic [7:0]    src_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          frame_done;

  always #5 clk = ~clk;

  scanline_plane_merger #(
    .W      (W),
    .H      (H),
    .THRESH (8'd128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_ok     (src_ok),
    .src_req    (src_req),
    .src_data   (src_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int unsigned x;
    int unsigned y;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t sb[$];

  // Provider byte tables, per row: green plane then red plane.
  logic [7:0] gtab [H][W];
  logic [7:0] rtab [H][W];
  logic [7:0] g_model [W];

  function automatic logic [15:0] exp_pix(input logic [7:0] r, input logic [7:0] g);
`ifdef PLANE_THRESHOLD_EN
    return {14'b0, r >= 8'd128, g >= 8'd128};
`else
    return {r, g};
`endif
  endfunction

  // Provider model: a request seen in one cycle returns a byte the next.
  int unsigned prov_n = 0;
  initial begin
    logic req_s;
    int unsigned k, row, x;
    exp_t e;
    gtab[0] = '{8'd10, 8'd11, 8'd12, 8'd13};
    rtab[0] = '{8'd20, 8'd21, 8'd22, 8'd23};
    gtab[1] = '{8'd127, 8'd255, 8'd30, 8'd200};
    rtab[1] = '{8'd128, 8'd0, 8'd40, 8'd100};
    src_data = '0;
    forever begin
      @(negedge clk);
      req_s = src_req && rst;
      if (!rst) prov_n = 0;
      @(posedge clk);
      #1;
      if (req_s) begin
        k   = prov_n % (2 * W);
        row = (prov_n / (2 * W)) % H;
        if (k < W) begin
          src_data   = gtab[row][k];
          g_model[k] = gtab[row][k];
        end else begin
          x        = k - W;
          src_data = rtab[row][x];
          e.data   = exp_pix(rtab[row][x], g_model[x]);
          e.x      = x;
          e.y      = row;
          e.sof    = (x == 0) && (row == 0);
          e.eol    = (x == W - 1);
          sb.push_back(e);
        end
        prov_n++;
      end
    end
  end

  // Monitor: a transfer seen at the negedge completes on the next posedge.
  int unsigned xfer_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && pix_valid && pix_ready) begin
        check("done_before_last", 32'(frame_done), 32'd0);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("pix_x", 32'(pix_x), e.x);
          check("pix_y", 32'(pix_y), e.y);
          check("pix_sof", 32'(pix_sof), 32'(e.sof));
          check("pix_eol", 32'(pix_eol), 32'(e.eol));
        end
        xfer_cnt++;
      end
    end
  end

  task automatic wait_xfers(input int unsigned target, input int unsigned budget);
    for (int unsigned i = 0; i < budget && xfer_cnt < target; i++) @(negedge clk);
    check("xfer_timeout", 32'(xfer_cnt >= target), 32'd1);
  endtask

  task automatic do_reset(input logic ok);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    src_ok = ok;
    repeat (2) @(negedge clk);
    sb.delete();
    xfer_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    src_ok    = 1'b1;
    pix_ready = 1'b1;

    // Reset state
    repeat (5) begin
      @(negedge clk);
      check("rst_src_req", 32'(src_req), 32'd0);
    end
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
    check("rst_pix_sof", 32'(pix_sof), 32'd0);
    check("rst_pix_eol", 32'(pix_eol), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("req_idle_cycle", 32'(src_req), 32'd0);
    @(negedge clk);
    check("req_rise", 32'(src_req), 32'd1);

    // Backpressure mid-line: ten cycles with pix_ready low
    wait_xfers(2, 200);
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      check("stall_valid", 32'(pix_valid), 32'd1);
      check("stall_src_req", 32'(src_req), 32'd0);
      if (sb.size() != 0) begin
        check("stall_data", 32'(pix_data), 32'(sb[0].data));
        check("stall_x", 32'(pix_x), sb[0].x);
      end else begin
        check("stall_sb_size", 32'(sb.size()), 32'd1);
      end
    end
    @(posedge clk);
    #1;
    pix_ready = 1'b1;

    wait_xfers(W * H, 500);
    @(negedge clk);
    check("frame_done", 32'(frame_done), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("done_no_req", 32'(src_req), 32'd0);
    end

    // Reset during FETCH_R of row 1
    do_reset(1'b1);
    wait_xfers(W + 1, 500);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_src_req", 32'(src_req), 32'd0);
    check("midrst_valid", 32'(pix_valid), 32'd0);
    check("midrst_x", 32'(pix_x), 32'd0);
    check("midrst_y", 32'(pix_y), 32'd0);
    sb.delete();
    xfer_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_xfers(W * H, 600);
    @(negedge clk);
    check("frame_done_restart", 32'(frame_done), 32'd1);

    // src_ok held low after reset
    do_reset(1'b0);
    repeat (20) begin
      @(negedge clk);
      check("no_req_without_ok", 32'(src_req), 32'd0);
    end
    @(posedge clk);
    #1;
    src_ok = 1'b1;
    for (int unsigned i = 0; i < 5 && !src_req; i++) @(negedge clk);
    check("req_after_ok", 32'(src_req), 32'd1);
    wait_xfers(W * H, 600);
    @(negedge clk);
    check("frame_done_late_ok", 32'(frame_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
